cam_frame_capture: RTL

- Sits directly downstream of the camera I/O stage.
- Consumes its registered row-valid, frame-valid and byte stream plus the shutter request.
- Assembles byte pairs into 16-bit RGB565 pixels and captures exactly one complete frame per shutter press.
- Emits pixels with linear frame-buffer write addresses and coordinates, and flags malformed lines and frames.

---
 rtl/cam_pkg.sv | 11 +
 rtl/cam_edge_det.sv | 16 +
 rtl/cam_frame_capture.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and default geometry for the camera capture path
package cam_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, SYNC, CAPTURE} state_t;
  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
endpackage

// File: rtl/cam_edge_det.sv
// cam_edge_det: one-sample history register giving rise/fall strobes for a level
module cam_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic prev_q, prev_d;
  // next history sample is simply the current level
  always_comb prev_d = d;
  // history register, cleared by reset
  always_ff @(posedge clk) prev_q <= reset ? 1'b0 : prev_d;
  assign rise = d & ~prev_q;
  assign fall = ~d & prev_q;
endmodule

// File: rtl/cam_frame_capture.sv
// cam_frame_capture: assembles RGB565 byte pairs and captures one frame per shutter press
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 17
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        href,
  input  logic                        vsync,
  input  logic [7:0]                  data,
  input  logic                        shutter,
  output logic                        pix_valid,
  output logic [15:0]                 pix_data,
  output logic [ADDR_W-1:0]           pix_addr,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        err_line,
  output logic                        err_frame
);
  localparam int XW  = $clog2(H_ACTIVE + 1);
  localparam int YW  = $clog2(V_ACTIVE + 1);
  localparam int PXW = $clog2(H_ACTIVE);
  localparam int PYW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0]     X_MAX  = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX  = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(H_ACTIVE);

  logic shutter_rise, shutter_fall_unused;
  logic href_rise_unused, href_fall;
  logic vsync_rise, vsync_fall;

  cam_edge_det u_shutter (.clk(clk), .reset(reset), .d(shutter), .rise(shutter_rise), .fall(shutter_fall_unused));
  cam_edge_det u_href    (.clk(clk), .reset(reset), .d(href),    .rise(href_rise_unused), .fall(href_fall));
  cam_edge_det u_vsync   (.clk(clk), .reset(reset), .d(vsync),   .rise(vsync_rise),   .fall(vsync_fall));

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic                phase_q, phase_d;
  logic [7:0]          hi_q, hi_d;
  logic                pix_valid_q, pix_valid_d;
  rgb565_t             pix_data_q, pix_data_d;
  logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
  logic [PXW-1:0]      pix_x_q, pix_x_d;
  logic [PYW-1:0]      pix_y_q, pix_y_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;
  logic                err_line_q, err_line_d;
  logic                err_frame_q, err_frame_d;

  // capture sequencing, pixel assembly and line/frame bookkeeping
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    row_base_d    = row_base_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_addr_d    = pix_addr_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    err_line_d    = err_line_q;
    err_frame_d   = err_frame_q;
    case (state_q)
      IDLE: if (shutter_rise) begin
        state_d     = ARMED;
        err_line_d  = 1'b0;
        err_frame_d = 1'b0;
      end
      ARMED: if (vsync_rise) state_d = SYNC;
      SYNC: if (vsync_fall) begin
        state_d       = CAPTURE;
        x_d           = '0;
        y_d           = '0;
        row_base_d    = '0;
        phase_d       = 1'b0;
        frame_start_d = 1'b1;
      end
      CAPTURE: begin
        if (href) begin
          phase_d = ~phase_q;
          hi_d    = phase_q ? hi_q : data;
          if (phase_q && x_q < X_MAX) begin
            x_d         = x_q + XW'(1);
            pix_valid_d = y_q < Y_MAX;
            pix_data_d  = pix_valid_d ? {hi_q, data} : pix_data_q;
            pix_addr_d  = pix_valid_d ? row_base_q + ADDR_W'(x_q) : pix_addr_q;
            pix_x_d     = pix_valid_d ? x_q[PXW-1:0] : pix_x_q;
            pix_y_d     = pix_valid_d ? y_q[PYW-1:0] : pix_y_q;
          end
        end
        if (href_fall) begin
          err_line_d = err_line_q | (x_q != X_MAX) | phase_q;
          x_d        = '0;
          phase_d    = 1'b0;
          y_d        = (y_q < Y_MAX) ? y_q + YW'(1) : y_q;
          row_base_d = (y_q < Y_MAX) ? row_base_q + A_STEP : row_base_q;
        end
        if (vsync_rise) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          err_frame_d  = err_frame_q | (y_d != Y_MAX);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs, all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      row_base_q    <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_addr_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      row_base_q    <= row_base_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_addr_q    <= pix_addr_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      err_line_q    <= err_line_d;
      err_frame_q   <= err_frame_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_addr    = pix_addr_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = state_q != IDLE;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;
endmodule
